mod_memstage_lsq: RTL and testbench

Parametrised memory stage for the pipelined x86-64 core. It sits between decode/operand-fetch (ID_MEM) and execute (MEM_EX). Each ID_MEM micro-op enters an in-order queue of DEPTH entries. The stage issues loads and stores one at a time to the data-memory port, sign- or zero-extends load data by access size, and hands each completed op plus its opaque control payload to execute over a valid/ready handshake. Unlike the single-slot stage it replaces, it buffers several ops, supports 1/2/4/8-byte accesses, and supports pipeline flush.

---
 rtl/mod_memstage_lsq.sv | 209 ++++++++++++++++++++
 tb/tb_mod_memstage_lsq.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_memstage_lsq.sv
// Memory stage with an in-order op queue: issues one load/store at a time to the
// data port, extends load data by size, and presents each completed op to EX.
module mod_memstage_lsq #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int PAYLOAD_W = 160,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_kind,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [DATA_W-1:0]          in_wdata,
    input  logic [1:0]                 in_size,
    input  logic                       in_signed,
    input  logic [PAYLOAD_W-1:0]       in_payload,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_req_we,
    output logic [ADDR_W-1:0]          mem_req_addr,
    output logic [DATA_W-1:0]          mem_req_wdata,
    output logic [1:0]                 mem_req_size,
    input  logic                       mem_rsp_valid,
    input  logic [DATA_W-1:0]          mem_rsp_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_kind,
    output logic [DATA_W-1:0]          out_data,
    output logic [PAYLOAD_W-1:0]       out_payload,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       busy,
    output logic [2:0]                 dbg_state
);
    // Handshakes (in_*, mem_req_*, out_*): a transfer happens on a rising edge where
    // valid and ready are both high; once raised, valid and its fields hold until the
    // transfer, except that flush may withdraw them.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] KIND_LOAD  = 2'b01;
    localparam logic [1:0] KIND_STORE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [1:0]           q_kind    [DEPTH];
    logic [ADDR_W-1:0]    q_addr    [DEPTH];
    logic [DATA_W-1:0]    q_wdata   [DEPTH];
    logic [1:0]           q_size    [DEPTH];
    logic                 q_signed  [DEPTH];
    logic [PAYLOAD_W-1:0] q_payload [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic             rst_done;

    logic [1:0]           out_kind_r;
    logic [DATA_W-1:0]    out_data_r;
    logic [PAYLOAD_W-1:0] out_payload_r;

    logic                 push, pop, out_load, head_valid, head_is_mem;
    logic [1:0]           h_kind, h_size;
    logic [ADDR_W-1:0]    h_addr;
    logic [DATA_W-1:0]    h_wdata, out_data_nxt;
    logic                 h_signed;
    logic [PAYLOAD_W-1:0] h_payload;

    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] d,
                                                      input logic [1:0] size,
                                                      input logic sgn);
        int                nbits;
        logic [DATA_W-1:0] mask;
        logic              sbit;
        nbits = 8 << size;
        mask  = {DATA_W{1'b1}} >> (DATA_W - nbits);
        sbit  = |(d & mask & ~(mask >> 1));
        return (sgn && sbit) ? (d | ~mask) : (d & mask);
    endfunction

    assign h_kind      = q_kind[head];
    assign h_addr      = q_addr[head];
    assign h_wdata     = q_wdata[head];
    assign h_size      = q_size[head];
    assign h_signed    = q_signed[head];
    assign h_payload   = q_payload[head];
    assign head_valid  = (count != '0);
    assign head_is_mem = (h_kind == KIND_LOAD) || (h_kind == KIND_STORE);

    // rst_done keeps in_ready low through reset and for the first cycle after it.
    assign in_ready = rst_done && (count < CNT_W'(DEPTH)) && !flush && (state != S_DRAIN);
    assign push     = in_valid && in_ready;

    assign out_data_nxt = (state == S_WAIT && h_kind == KIND_LOAD)
                        ? extend_load(mem_rsp_data, h_size, h_signed) : h_wdata;

    always_comb begin
        state_nxt     = state;
        pop           = 1'b0;
        out_load      = 1'b0;
        mem_req_valid = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (head_valid) begin
                    if (head_is_mem) begin
                        state_nxt = S_REQ;
                    end else begin
                        out_load  = 1'b1;
                        pop       = 1'b1;
                        state_nxt = S_PRESENT;
                    end
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    out_load  = 1'b1;
                    pop       = 1'b1;
                    state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (mem_rsp_valid) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // A flush with a request still owed a response must swallow that response.
        if (flush) begin
            pop      = 1'b0;
            out_load = 1'b0;
            if ((state == S_WAIT && !mem_rsp_valid) ||
                (state == S_REQ && mem_req_ready) ||
                (state == S_DRAIN && !mem_rsp_valid))
                state_nxt = S_DRAIN;
            else
                state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            rst_done      <= 1'b0;
            out_kind_r    <= '0;
            out_data_r    <= '0;
            out_payload_r <= '0;
        end else begin
            state    <= state_nxt;
            rst_done <= 1'b1;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
            if (out_load) begin
                out_kind_r    <= h_kind;
                out_data_r    <= out_data_nxt;
                out_payload_r <= h_payload;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_kind[tail]    <= in_kind;
            q_addr[tail]    <= in_addr;
            q_wdata[tail]   <= in_wdata;
            q_size[tail]    <= in_size;
            q_signed[tail]  <= in_signed;
            q_payload[tail] <= in_payload;
        end
    end

    assign mem_req_we    = (state == S_REQ) && (h_kind == KIND_STORE);
    assign mem_req_addr  = (state == S_REQ) ? h_addr  : '0;
    assign mem_req_wdata = (state == S_REQ) ? h_wdata : '0;
    assign mem_req_size  = (state == S_REQ) ? h_size  : '0;

    assign out_valid   = (state == S_PRESENT);
    assign out_kind    = out_kind_r;
    assign out_data    = out_data_r;
    assign out_payload = out_payload_r;
    assign occupancy   = count;
    assign busy        = (state != S_IDLE) || (count != '0);
    assign dbg_state   = state;

endmodule

// File: tb/tb_mod_memstage_lsq.sv
// Bench for mod_memstage_lsq: directed scenarios plus random traffic, checked
// against a program-order scoreboard and a simple word-per-address memory model.
module tb_mod_memstage_lsq;
    localparam int ADDR_W = 64, DATA_W = 64, PAYLOAD_W = 160, DEPTH = 4;

    logic clk = 1'b0;
    logic reset, flush, in_valid, in_ready, in_signed;
    logic [1:0] in_kind, in_size, mem_req_size, out_kind;
    logic [ADDR_W-1:0] in_addr, mem_req_addr;
    logic [DATA_W-1:0] in_wdata, mem_req_wdata, mem_rsp_data, out_data;
    logic [PAYLOAD_W-1:0] in_payload, out_payload;
    logic mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid, out_valid, out_ready, busy;
    logic [$clog2(DEPTH):0] occupancy;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    mod_memstage_lsq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_size(in_size), .in_signed(in_signed), .in_payload(in_payload),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_size(mem_req_size),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_data(out_data),
        .out_payload(out_payload), .occupancy(occupancy), .busy(busy), .dbg_state(dbg_state)
    );

    typedef struct {
        logic [1:0]           kind;
        logic [DATA_W-1:0]    data;
        logic [PAYLOAD_W-1:0] payload;
    } out_t;
    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [1:0]        size;
    } req_t;

    out_t exp_q[$];
    req_t exp_req[$];
    logic [63:0] mem_init [logic [63:0]];

    int n_checks = 0, n_fail = 0;
    int ready_mode = 1, rsp_lat = 0, out_mode = 0, rsp_wait = 0;
    logic [ADDR_W-1:0] rsp_addr;
    logic rsp_is_load;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (mem_init.exists(a)) return mem_init[a];
        return {~a[31:0], a[31:0] ^ 32'h5A5A_C3C3};
    endfunction

    // Load result: keep the low 1/2/4/8 bytes, fill upward with the top kept bit or zero.
    function automatic logic [63:0] model_ext(input logic [63:0] d, input logic [1:0] size, input logic sgn);
        logic [63:0] mask, v;
        int nb;
        case (size)
            2'd0: mask = 64'h0000_0000_0000_00FF;
            2'd1: mask = 64'h0000_0000_0000_FFFF;
            2'd2: mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        nb = 8 * (2 ** size);
        v = d & mask;
        if (sgn && ((v >> (nb - 1)) & 64'd1) == 64'd1) v = v | ~mask;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the op is accepted.
    task automatic send(input logic [1:0] kind, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [1:0] size, input logic sgn);
        logic [PAYLOAD_W-1:0] pl;
        int guard;
        out_t o;
        req_t r;
        pl = {$urandom, $urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1; in_kind = kind; in_addr = addr; in_wdata = wdata;
        in_size = size; in_signed = sgn; in_payload = pl;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            check("send_ready", in_ready, 1);
        end else begin
            o.kind = kind; o.payload = pl;
            o.data = (kind == 2'b01) ? model_ext(mem_word(addr), size, sgn) : wdata;
            exp_q.push_back(o);
            if (kind == 2'b01 || kind == 2'b10) begin
                r.we = (kind == 2'b10); r.addr = addr; r.wdata = wdata; r.size = size;
                exp_req.push_back(r);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int g;
        g = 0;
        while ((busy || exp_q.size() != 0 || rsp_wait != 0) && g < max) begin
            @(negedge clk);
            g++;
        end
        if (g >= max) begin
            check("idle_busy", busy, 0);
            check("idle_pending", exp_q.size(), 0);
        end
    endtask

    // Memory responder: acts 2ns after each posedge, checks each accepted request.
    initial begin : responder
        int r;
        req_t e;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_rsp_valid = 1'b0;
            if (rsp_wait > 0) begin
                rsp_wait--;
                if (rsp_wait == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data = rsp_is_load ? mem_word(rsp_addr) : {$urandom, $urandom};
                end
            end
            case (ready_mode)
                0: r = 0;
                1: r = 1;
                default: r = $urandom_range(0, 1);
            endcase
            mem_req_ready = (r != 0);
            if (!reset && mem_req_valid && mem_req_ready) begin
                if (exp_req.size() == 0) begin
                    check("req_unexpected", mem_req_valid, 0);
                end else begin
                    e = exp_req.pop_front();
                    check("req_we", mem_req_we, e.we);
                    check("req_addr", mem_req_addr, e.addr);
                    check("req_size", mem_req_size, e.size);
                    if (e.we) check("req_wdata", mem_req_wdata, e.wdata);
                end
                rsp_wait = (rsp_lat == 0) ? $urandom_range(1, 4) : rsp_lat;
                rsp_addr = mem_req_addr;
                rsp_is_load = !mem_req_we;
            end
        end
    end

    // Output sink and scoreboard.
    initial begin : sink
        out_t e;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (out_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 1) != 0);
            endcase
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_kind", out_kind, e.kind);
                    check("out_data", out_data, e.data);
                    check("out_payload", out_payload, e.payload);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int g;
        logic [PAYLOAD_W-1:0] snap_pl;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_kind = '0; in_addr = '0;
        in_wdata = '0; in_size = '0; in_signed = 1'b0; in_payload = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 3'd0);
        check("rst_out_data", out_data, 0);
        reset = 1'b0;
        #1;
        check("in_ready_first_cycle", in_ready, 0);
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);

        // Pass-through ops and their two-cycle latency.
        send(2'b00, 64'h0, 64'h11, 2'd3, 1'b0);
        check("pass_lat_1", out_valid, 0);
        @(negedge clk);
        check("pass_lat_2", out_valid, 1);
        send(2'b00, 64'h0, 64'h22, 2'd3, 1'b0);
        send(2'b11, 64'h0, 64'h33, 2'd3, 1'b0);
        wait_idle(100);
        check("pass_occ_zero", occupancy, 0);

        // Load extension cases.
        mem_init[64'h100] = 64'h0000_0000_0000_0080;
        mem_init[64'h200] = 64'h0000_0000_8000_0000;
        mem_init[64'h300] = 64'h1234_5678_9ABC_8001;
        send(2'b01, 64'h100, 64'h0, 2'd0, 1'b1);
        send(2'b01, 64'h100, 64'h0, 2'd0, 1'b0);
        send(2'b01, 64'h200, 64'h0, 2'd2, 1'b1);
        send(2'b01, 64'h300, 64'h0, 2'd1, 1'b1);
        send(2'b01, 64'h300, 64'h0, 2'd3, 1'b1);
        wait_idle(200);

        // Fill the queue while memory refuses requests.
        ready_mode = 0;
        for (int i = 0; i < 4; i++) send(2'b01, 64'h400 + 64'(i * 8), 64'h0, 2'd3, 1'b0);
        check("full_in_ready", in_ready, 0);
        check("full_occ", occupancy, 4);
        check("full_req_valid", mem_req_valid, 1);
        in_valid = 1'b1; in_kind = 2'b00; in_wdata = 64'hBAD;
        repeat (3) begin
            @(negedge clk);
            check("full_occ_hold", occupancy, 4);
            check("full_req_addr_hold", mem_req_addr, 64'h400);
            check("full_req_valid_hold", mem_req_valid, 1);
        end
        in_valid = 1'b0;
        ready_mode = 2;
        wait_idle(300);

        // Store with delayed acceptance and a fixed ack delay.
        ready_mode = 0; rsp_lat = 3;
        send(2'b10, 64'h1000, 64'hDEAD, 2'd3, 1'b0);
        g = 0;
        while (!mem_req_valid && g < 20) begin @(negedge clk); g++; end
        check("st_req_valid", mem_req_valid, 1);
        check("st_req_we", mem_req_we, 1);
        check("st_req_addr", mem_req_addr, 64'h1000);
        check("st_req_wdata", mem_req_wdata, 64'hDEAD);
        check("st_req_size", mem_req_size, 2'd3);
        repeat (2) @(negedge clk);
        check("st_hold_valid", mem_req_valid, 1);
        check("st_hold_wdata", mem_req_wdata, 64'hDEAD);
        ready_mode = 1;
        g = 0;
        while (!mem_rsp_valid && g < 20) begin @(negedge clk); g++; end
        check("st_ack_seen", mem_rsp_valid, 1);
        check("st_out_before", out_valid, 0);
        @(negedge clk);
        check("st_out_after", out_valid, 1);
        check("st_out_data", out_data, 64'hDEAD);
        wait_idle(100);
        rsp_lat = 0;

        // Presented op held by EX: outputs stable, no further memory request.
        out_mode = 1;
        send(2'b01, 64'h2000, 64'h0, 2'd3, 1'b0);
        send(2'b01, 64'h2008, 64'h0, 2'd1, 1'b1);
        g = 0;
        while (!out_valid && g < 50) begin @(negedge clk); g++; end
        check("stall_valid", out_valid, 1);
        snap_pl = out_payload;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid_hold", out_valid, 1);
            check("stall_data", out_data, mem_word(64'h2000));
            check("stall_payload", out_payload, snap_pl);
            check("stall_no_req", mem_req_valid, 0);
        end
        out_mode = 0;
        wait_idle(100);

        // Flush with a load outstanding and two ops queued behind it.
        rsp_lat = 10;
        send(2'b01, 64'h3000, 64'h0, 2'd3, 1'b0);
        send(2'b00, 64'h0, 64'h55, 2'd3, 1'b0);
        send(2'b00, 64'h0, 64'h66, 2'd3, 1'b0);
        g = 0;
        while (dbg_state != 3'd2 && g < 20) begin @(negedge clk); g++; end
        check("fl_in_wait", dbg_state, 3'd2);
        check("fl_occ_before", occupancy, 3);
        flush = 1'b1;
        in_valid = 1'b1; in_kind = 2'b00; in_wdata = 64'h99;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        exp_req.delete();
        check("fl_occ", occupancy, 0);
        check("fl_out_valid", out_valid, 0);
        check("fl_state_drain", dbg_state, 3'd4);
        check("fl_in_ready_drain", in_ready, 0);
        g = 0;
        while (dbg_state != 3'd0 && g < 30) begin @(negedge clk); g++; end
        check("fl_back_idle", dbg_state, 3'd0);
        repeat (3) @(negedge clk);
        check("fl_no_output", out_valid, 0);
        rsp_lat = 0;
        send(2'b00, 64'h0, 64'h77, 2'd3, 1'b0);
        wait_idle(100);

        // Random traffic.
        ready_mode = 2; out_mode = 2;
        for (int i = 0; i < 150; i++) begin
            send(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle(3000);
        check("final_exp_empty", exp_q.size(), 0);
        check("final_req_empty", exp_req.size(), 0);
        check("final_occ", occupancy, 0);
        check("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
